// File: rtl/fifo_ctrl_16x8.sv
// Pointer, occupancy and flag controller that turns an external 16x8 registered-read
// RAM into a first-in-first-out buffer. Flags are registered from the next count value.
module fifo_ctrl_16x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_w_add,
  output logic [ADDR_WIDTH-1:0] ram_r_add,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  dv_q, dv_d;

  // Accept decisions use only registered flags, so a read never frees space
  // for a write in the same cycle and there is no empty-bypass.
  always_comb begin
    wr_acc = wr_en & ~full_q & ~reset;
    rd_acc = rd_en & ~empty_q & ~reset;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);

    ovf_d = wr_en & full_q;
    unf_d = rd_en & empty_q;
    dv_d  = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dv_q     <= dv_d;
    end
  end

  assign ram_we       = wr_acc;
  assign ram_re       = rd_acc;
  assign ram_w_add    = wr_ptr_q;
  assign ram_r_add    = rd_ptr_q;
  assign ram_data_in  = din;
  assign dout         = ram_data_out;
  assign dout_valid   = dv_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Bench for fifo_ctrl_16x8: vector table, directed corner sequences and random traffic,
// with a queue-based reference model and a behavioural 16x8 registered-read RAM.
module tb_fifo_ctrl_16x8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow, ram_we, ram_re;
  logic [3:0] ram_w_add, ram_r_add;
  logic [7:0] ram_data_in, ram_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_ctrl_16x8 dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_we(ram_we), .ram_re(ram_re),
    .ram_w_add(ram_w_add), .ram_r_add(ram_r_add), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  logic [7:0] mem [16];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_w_add] <= ram_data_in;
    if (ram_re) ram_q <= mem[ram_r_add];
  end
  assign ram_data_out = ram_q;

  // Reference model state
  logic [7:0] q[$];
  int  wp = 0, rp = 0;
  bit  m_ovf = 0, m_unf = 0, m_dv = 0;
  logic [7:0] m_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input logic [7:0] d, input bit rd);
    bit mfull, mempty, wa, ra;
    @(negedge clk);
    reset = rst; wr_en = wr; din = d; rd_en = rd;
    #1;
    mfull  = (q.size() == 16);
    mempty = (q.size() == 0);
    wa = wr && !mfull && !rst;
    ra = rd && !mempty && !rst;
    chk("ram_we", ram_we, wa);
    chk("ram_re", ram_re, ra);
    chk("ram_data_in", ram_data_in, d);
    chk("ram_w_add", ram_w_add, wp % 16);
    chk("ram_r_add", ram_r_add, rp % 16);
    if (rst) begin
      q.delete(); wp = 0; rp = 0; m_ovf = 0; m_unf = 0; m_dv = 0;
    end else begin
      m_ovf = wr && mfull;
      m_unf = rd && mempty;
      m_dv  = ra;
      if (ra) begin m_dout = q.pop_front(); rp++; end
      if (wa) begin q.push_back(d); wp++; end
    end
    @(posedge clk);
    #1;
    chk("count", count, q.size());
    chk("full", full, q.size() == 16);
    chk("empty", empty, q.size() == 0);
    chk("almost_full", almost_full, q.size() >= 14);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("dout_valid", dout_valid, m_dv);
    if (m_dv) chk("dout", dout, m_dout);
  endtask

  typedef struct {
    bit rst; bit wr; logic [7:0] d; bit rd;
    int cnt; bit fu; bit em; bit af; bit ae; bit ov; bit un; bit dv; logic [7:0] dout;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int dvrun;
    bit wrapped;
    logic [3:0] wa0, ra0;
    logic [3:0] prev_w;
    int pw, pr;

    tbl = '{
      '{1,0,8'h00,0, 0, 0,1,0,1, 0,0,0, 8'h00},
      '{0,0,8'h00,0, 0, 0,1,0,1, 0,0,0, 8'h00},
      '{0,0,8'h00,0, 0, 0,1,0,1, 0,0,0, 8'h00},
      '{0,0,8'h00,0, 0, 0,1,0,1, 0,0,0, 8'h00},
      '{0,0,8'h00,1, 0, 0,1,0,1, 0,1,0, 8'h00},
      '{0,1,8'h11,0, 1, 0,0,0,1, 0,0,0, 8'h00},
      '{0,1,8'h22,0, 2, 0,0,0,1, 0,0,0, 8'h00},
      '{0,1,8'h33,0, 3, 0,0,0,0, 0,0,0, 8'h00},
      '{0,1,8'h44,1, 3, 0,0,0,0, 0,0,1, 8'h11},
      '{0,0,8'h00,1, 2, 0,0,0,1, 0,0,1, 8'h22},
      '{0,0,8'h00,1, 1, 0,0,0,1, 0,0,1, 8'h33},
      '{0,0,8'h00,1, 0, 0,1,0,1, 0,0,1, 8'h44},
      '{0,1,8'h55,1, 1, 0,0,0,1, 0,1,0, 8'h00},
      '{0,0,8'h00,1, 0, 0,1,0,1, 0,0,1, 8'h55},
      '{0,0,8'h00,0, 0, 0,1,0,1, 0,0,0, 8'h00}
    };

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_full", i), full, tbl[i].fu);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].em);
      chk($sformatf("vec%0d_afull", i), almost_full, tbl[i].af);
      chk($sformatf("vec%0d_aempty", i), almost_empty, tbl[i].ae);
      chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ov);
      chk($sformatf("vec%0d_unf", i), underflow, tbl[i].un);
      chk($sformatf("vec%0d_dv", i), dout_valid, tbl[i].dv);
      if (tbl[i].dv) chk($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
    end

    // Fill to 16, then one refused write
    step(1, 0, 8'h00, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'(i), 0);
      if (i == 13) chk("af_below_level", almost_full, 0);
      if (i == 14) chk("af_at_level", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_wptr_wrap", ram_w_add, 0);
    step(0, 1, 8'hEE, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    step(0, 0, 8'h00, 0);
    chk("ovf_clears", overflow, 0);

    // Back-to-back drain
    dvrun = 0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 8'h00, 1);
      if (dout_valid) dvrun++;
      chk("drain_dout", dout, 8'(i));
    end
    chk("dv_run", dvrun, 16);
    step(0, 0, 8'h00, 1);
    chk("unf_pulse", underflow, 1);
    chk("unf_dv", dout_valid, 0);
    chk("unf_empty", empty, 1);

    // Pointer wrap mid-stream
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
    wrapped = 0;
    for (int i = 0; i < 16; i++) begin
      prev_w = ram_w_add;
      step(0, 1, 8'(8'hA0 + i), 0);
      if (prev_w == 4'd15 && ram_w_add == 4'd0) wrapped = 1;
    end
    chk("w_add_wrapped", wrapped, 1);
    step(0, 1, 8'hBB, 1);
    chk("full_simul_count", count, 15);
    chk("full_simul_ovf", overflow, 1);
    chk("full_simul_dout", dout, 8'hA0);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      chk("wrap_dout", dout, 8'(8'hA0 + i));
    end

    // Simultaneous at empty and at count 5
    step(0, 1, 8'hC3, 1);
    chk("empty_simul_count", count, 1);
    chk("empty_simul_unf", underflow, 1);
    chk("empty_simul_dv", dout_valid, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hD0 + i), 0);
    wa0 = ram_w_add; ra0 = ram_r_add;
    step(0, 1, 8'hD4, 1);
    chk("c5_count", count, 5);
    chk("c5_wptr", ram_w_add, 4'(wa0 + 4'd1));
    chk("c5_rptr", ram_r_add, 4'(ra0 + 4'd1));
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

    // Reset mid-read at count 9
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h70 + i), 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dv", dout_valid, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    chk("post_rst_dv", dout_valid, 1);
    chk("post_rst_dout", dout, 8'h5A);

    // Random traffic, biased per phase toward filling or draining
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 30;
      pr = (ph % 2 == 0) ? 30 : 80;
      if (ph >= 6) begin pw = 50; pr = 50; end
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(0, 63) == 0,
             $urandom_range(0, 99) < pw,
             8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < pr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
